// File: rtl/pe_bus_decoder_if.sv
// Bus bundle between the PE core data port, the decoder and the mapped slaves.
// The decoder connects through the slave modport; the core/slave side uses master.
interface pe_bus_decoder_if #(
  parameter int N_SLAVES = 4,
  parameter int BASE_BIT = 24
);
  logic                     cpu_en_i;
  logic [3:0]               cpu_we_i;
  logic [31:0]              cpu_addr_i;
  logic [31:0]              cpu_data_i;
  logic [31:0]              cpu_data_o;
  logic                     cpu_stall_o;
  logic [N_SLAVES-1:0]      slv_en_o;
  logic [3:0]               slv_we_o;
  logic [BASE_BIT-1:0]      slv_addr_o;
  logic [31:0]              slv_data_o;
  logic [N_SLAVES*32-1:0]   slv_data_i;
  logic [N_SLAVES-1:0]      slv_rvalid_i;
  logic                     err_o;
  logic [31:0]              err_addr_o;

  modport slave (
    input  cpu_en_i, cpu_we_i, cpu_addr_i, cpu_data_i, slv_data_i, slv_rvalid_i,
    output cpu_data_o, cpu_stall_o, slv_en_o, slv_we_o, slv_addr_o, slv_data_o,
           err_o, err_addr_o
  );

  modport master (
    output cpu_en_i, cpu_we_i, cpu_addr_i, cpu_data_i, slv_data_i, slv_rvalid_i,
    input  cpu_data_o, cpu_stall_o, slv_en_o, slv_we_o, slv_addr_o, slv_data_o,
           err_o, err_addr_o
  );
endinterface

// File: rtl/pe_bus_decoder.sv
// One-hot region decoder for the PE data port: posted writes, reads with fixed or
// rvalid-driven latency, core stall while waiting, read timeout and bus-error reporting.
module pe_bus_decoder #(
  parameter int                  N_SLAVES       = 4,
  parameter int                  BASE_BIT       = 24,
  parameter logic [N_SLAVES-1:0] FIXED_LAT_MASK = '1,
  parameter int                  TIMEOUT        = 16,
  parameter logic [31:0]         ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  pe_bus_decoder_if.slave   bus
);

  localparam int TAG_W = 32 - BASE_BIT;
  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, RESP} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [31:0]      addr_q, addr_d;
  logic             rerr_q, rerr_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic [31:0]      err_addr_q, err_addr_d;

  logic [N_SLAVES-1:0] hit;
  logic [SEL_W-1:0]    hit_idx;
  logic                mapped;
  logic                fixed_sel, rvalid_sel, timeout_hit, resp_valid;
  logic                accept, rd_req, wr_req;

  // A region matches only when its single tag bit is set; every other tag is unmapped.
  always_comb begin
    hit     = '0;
    hit_idx = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (bus.cpu_addr_i[31:BASE_BIT] == (TAG_W'(1) << k)) begin
        hit[k]  = 1'b1;
        hit_idx = SEL_W'(k);
      end
    end
  end

  assign mapped = |hit;

  // Rvalid outranks the timeout, so timeout_hit excludes every other response source.
  always_comb begin
    fixed_sel   = FIXED_LAT_MASK[sel_q];
    rvalid_sel  = bus.slv_rvalid_i[sel_q];
    timeout_hit = (state_q == RESP) && !rerr_q && !fixed_sel && !rvalid_sel &&
                  (TIMEOUT != 0) && (wait_cnt_q == CNT_W'(TIMEOUT));
    resp_valid  = (state_q == RESP) && (rerr_q || fixed_sel || rvalid_sel || timeout_hit);
    accept      = (state_q == IDLE) || resp_valid;
    rd_req      = accept && bus.cpu_en_i && (bus.cpu_we_i == 4'b0000);
    wr_req      = accept && bus.cpu_en_i && (bus.cpu_we_i != 4'b0000);
  end

  assign bus.slv_en_o    = accept ? (hit & {N_SLAVES{bus.cpu_en_i}}) : '0;
  assign bus.slv_we_o    = bus.cpu_we_i;
  assign bus.slv_addr_o  = bus.cpu_addr_i[BASE_BIT-1:0];
  assign bus.slv_data_o  = bus.cpu_data_i;
  assign bus.cpu_stall_o = (state_q == RESP) && !resp_valid;
  assign bus.cpu_data_o  = !resp_valid              ? 32'h0 :
                           (rerr_q || timeout_hit)  ? ERR_DATA :
                           bus.slv_data_i[32*int'(sel_q) +: 32];
  // A timeout is reported in the response cycle itself; unmapped accesses a cycle later.
  assign bus.err_o       = err_pulse_q | timeout_hit;
  assign bus.err_addr_o  = timeout_hit ? addr_q : err_addr_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    rerr_d      = rerr_q;
    wait_cnt_d  = wait_cnt_q;
    err_pulse_d = 1'b0;
    err_addr_d  = err_addr_q;

    if (timeout_hit) err_addr_d = addr_q;
    if ((rd_req || wr_req) && !mapped) begin
      err_pulse_d = 1'b1;
      err_addr_d  = bus.cpu_addr_i;
    end

    if (rd_req) begin
      state_d    = RESP;
      sel_d      = hit_idx;
      addr_d     = bus.cpu_addr_i;
      rerr_d     = !mapped;
      wait_cnt_d = CNT_W'(1);
    end else if (resp_valid) begin
      state_d = IDLE;
    end else if ((state_q == RESP) && (wait_cnt_q != '1)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      addr_q      <= '0;
      rerr_q      <= 1'b0;
      wait_cnt_q  <= '0;
      err_pulse_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      rerr_q      <= rerr_d;
      wait_cnt_q  <= wait_cnt_d;
      err_pulse_q <= err_pulse_d;
      err_addr_q  <= err_addr_d;
    end
  end

endmodule
